rom_loader: RTL and testbench
=============================

// Module: rom_loader
// PURPOSE
//  Streams a Hack program image into Computer instruction memory over a valid/ready word
//  interface, then releases the CPU from reset. Writer end of the ROM path the CPU reads:
//  replaces $readmemb file loading so benches and boards can download programs at runtime.
//  Sits between a host word source and the ROM write port. Owns the Computer's reset input.
// PARAMETERS
//  ADDR_WIDTH      15     ROM address width; capacity 2**ADDR_WIDTH words
//  DATA_WIDTH      16     instruction word width
//  RELEASE_CYCLES  2      cycles cpu_reset stays high after a verified load (>=1)
// PORTS
//  clk        in   1            rising-edge clock
//  reset      in   1            asynchronous, active-low
//  start      in   1            load request, sampled in IDLE/DONE/ERROR only
//  len        in   ADDR_WIDTH+1 word count, sampled with start
//  in_valid   in   1            source has a word
//  in_data    in   DATA_WIDTH   program word, or checksum word after the last program word
//  in_ready   out  1            loader accepts in_data this cycle
//  rom_we     out  1            ROM write strobe
//  rom_addr   out  ADDR_WIDTH   ROM write address
//  rom_wdata  out  DATA_WIDTH   ROM write data
//  cpu_reset  out  1            active-high reset to Computer
//  busy       out  1            load in progress (LOAD/CHECK/RELEASE)
//  done       out  1            image loaded and verified, CPU running
//  error      out  1            len out of range or checksum mismatch
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE; in_ready=0, rom_we=0, rom_addr=0, rom_wdata=0,
//   cpu_reset=1, busy=0, done=0, error=0; word count and checksum cleared.
//  States: IDLE, LOAD, CHECK, RELEASE, DONE, ERROR.
//  IDLE/DONE/ERROR + start: len > 2**ADDR_WIDTH -> ERROR; len==0 -> CHECK;
//   else -> LOAD. Any start clears count, checksum, done, error and asserts cpu_reset the next
//   cycle. A restart from DONE therefore halts the CPU.
//  LOAD: in_ready=1. Handshake = in_valid&in_ready. Per handshake: rom_we=1,
//   rom_addr=count, rom_wdata=in_data on the NEXT cycle (registered, 1-cycle latency).
//   count++. sum = sum + in_data mod 2**16. After the len-th handshake -> CHECK.
//   No-valid cycles stall with no write.
//  CHECK: in_ready=1. Next handshake word compared to sum (no ROM write):
//   equal -> RELEASE. Unequal -> ERROR.
//  RELEASE: cpu_reset=1 for exactly RELEASE_CYCLES cycles. This guarantees the last rom_we has
//   landed. Then -> DONE.
//  DONE: cpu_reset=0, done=1. ERROR: cpu_reset=1, error=1. Both hold until start or reset.
//  in_ready=0 in all states except LOAD/CHECK. rom_we=1 only in the cycle after a LOAD
//   handshake. start is ignored while busy.
//  rom_addr never wraps: len==2**ADDR_WIDTH writes address 0..max exactly once.
//  Reset mid-load: ROM contents partial/undefined, cpu_reset held, loader back in IDLE.
// STRUCTURE
//  Shared package hack_pkg: HACK_ADDR_WIDTH=15, HACK_DATA_WIDTH=16, loader state encoding
//   (IDLE..ERROR, 3-bit). Single module; no sub-module. FSM, count and sum live in one
//   always block on posedge clk / negedge reset.
//  Computer gains a ROM write port. Top-level wires loader.cpu_reset to Computer.reset.
// TESTING
//  1 reset low then high -> cpu_reset=1, in_ready=0, done=0, error=0, rom_we never pulses.
//  2 start,len=3; words 16'h0002,16'hEC10,16'h0000, checksum 16'hEC12 -> 3 writes at addr
//    0..2; RELEASE 2 cycles; done=1, cpu_reset=0. Run 50 cycles: Computer executes new ROM.
//  3 same image, checksum 16'hEC13 -> error=1, cpu_reset stays 1, done=0.
//  4 len=4, in_valid toggled 1/0 every cycle -> exactly 4 writes, addresses 0..3, no gaps.
//    No write occurs on a stalled cycle.
//  5 len=16'h8001 -> ERROR next cycle, no in_ready. Then len=0, checksum 0 -> DONE.
//  6 reset pulled low after 2 of 5 words -> immediate IDLE, cpu_reset=1. A new start,len=1
//    loads cleanly from addr 0.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared Hack platform constants and the ROM loader state encoding.
package hack_pkg;

  localparam int unsigned HACK_ADDR_WIDTH = 15;
  localparam int unsigned HACK_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    LDR_IDLE    = 3'd0,
    LDR_LOAD    = 3'd1,
    LDR_CHECK   = 3'd2,
    LDR_RELEASE = 3'd3,
    LDR_DONE    = 3'd4,
    LDR_ERROR   = 3'd5
  } ldr_state_e;

endpackage

// File: rtl/rom_loader.sv
// Streams a program image plus trailing checksum into instruction ROM over a
// valid/ready word interface, then releases the CPU from reset.
module rom_loader
  import hack_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = HACK_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = HACK_DATA_WIDTH,
  parameter int unsigned RELEASE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [DATA_WIDTH-1:0] rom_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  ldr_state_e            state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [REL_W-1:0]      rel_q, rel_d;
  logic                  rom_we_q, rom_we_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_WIDTH-1:0] rom_wdata_q, rom_wdata_d;

  logic                  len_over;

  // A length above 2**ADDR_WIDTH has the top bit set plus any lower bit.
  assign len_over = len[ADDR_WIDTH] && (len[ADDR_WIDTH-1:0] != '0);

  // State register together with word count, checksum and the registered ROM port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LDR_IDLE;
      count_q     <= '0;
      len_q       <= '0;
      sum_q       <= '0;
      rel_q       <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      rel_q       <= rel_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
    end
  end

  // Next-state, counters and the one-cycle-delayed ROM write.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    sum_d       = sum_q;
    rel_d       = rel_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    unique case (state_q)
      LDR_IDLE, LDR_DONE, LDR_ERROR: begin
        if (start) begin
          count_d = '0;
          sum_d   = '0;
          len_d   = len;
          if (len_over)        state_d = LDR_ERROR;
          else if (len == '0)  state_d = LDR_CHECK;
          else                 state_d = LDR_LOAD;
        end
      end
      LDR_LOAD: begin
        if (in_valid) begin
          rom_we_d    = 1'b1;
          rom_addr_d  = count_q[ADDR_WIDTH-1:0];
          rom_wdata_d = in_data;
          count_d     = count_q + CNT_ONE;
          sum_d       = sum_q + in_data;
          if (count_d == len_q) state_d = LDR_CHECK;
        end
      end
      LDR_CHECK: begin
        if (in_valid) begin
          if (in_data == sum_q) begin
            state_d = LDR_RELEASE;
            rel_d   = '0;
          end else begin
            state_d = LDR_ERROR;
          end
        end
      end
      LDR_RELEASE: begin
        if (rel_q == REL_LAST) state_d = LDR_DONE;
        else                   rel_d   = rel_q + 1'b1;
      end
      default: state_d = LDR_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    unique case (state_q)
      LDR_LOAD, LDR_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      LDR_RELEASE: busy = 1'b1;
      LDR_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      LDR_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len_i = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, rom_we, cpu_reset, busy, done, error;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;

  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned rel_cnt = 0;
  logic [14:0] wa_q[$];
  logic [15:0] wd_q[$];

  typedef struct {
    logic [15:0] len;
    logic [15:0] w[5];
    logic [15:0] chk;
    bit          tog;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  rom_loader #(.ADDR_WIDTH(15), .DATA_WIDTH(16), .RELEASE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len_i),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Capture ROM writes and count release-phase cycles away from the active edge.
  always @(negedge clk) begin
    if (rom_we) begin
      wa_q.push_back(rom_addr);
      wd_q.push_back(rom_wdata);
    end
    if (busy && !in_ready) rel_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    rel_cnt = 0;
  endtask

  task automatic do_start(input logic [15:0] l);
    start = 1'b1;
    len_i = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input bit tog, output bit ok);
    int unsigned g;
    g = 0;
    if (tog) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    ok = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int unsigned g;
    g = 0;
    while (!done && !error && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    if (!done && !error) check({name, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit ok;
    int unsigned n;
    int unsigned bad;
    string nm;
    nm = $sformatf("v%0d", idx);
    clear_mon();
    do_start(v.len);
    check({nm, "_cpu_reset_after_start"}, cpu_reset, 1);
    check({nm, "_done_after_start"}, done, 0);
    if (v.len > 16'h8000) begin
      check({nm, "_error_next_cycle"}, error, 1);
      check({nm, "_in_ready_err"}, in_ready, 0);
    end else begin
      n = v.len;
      for (int i = 0; i <= int'(n); i++) begin
        send_word((i < int'(n)) ? v.w[i] : v.chk, v.tog, ok);
        if (!ok) check({nm, "_in_ready_timeout"}, 32'd0, 32'd1);
      end
    end
    wait_end(nm);
    n = (v.len > 16'h8000) ? 0 : v.len;
    check({nm, "_write_count"}, wa_q.size(), n);
    bad = 0;
    for (int i = 0; i < int'(n) && i < wa_q.size(); i++)
      if (wa_q[i] != 15'(i) || wd_q[i] != v.w[i]) bad++;
    check({nm, "_write_contents_bad"}, bad, 0);
    check({nm, "_release_cycles"}, rel_cnt, v.exp_done ? 2 : 0);
    check({nm, "_done"}, done, v.exp_done);
    check({nm, "_error"}, error, v.exp_err);
    check({nm, "_cpu_reset"}, cpu_reset, !v.exp_done);
    check({nm, "_in_ready_idle"}, in_ready, 0);
  endtask

  initial begin
    bit ok;
    int unsigned bad;
    vec_t v;

    vecs[0] = '{len:16'd3, w:'{16'h0002, 16'hEC10, 16'h0000, 16'h0, 16'h0}, chk:16'hEC12, tog:0, exp_done:1, exp_err:0};
    vecs[1] = '{len:16'd3, w:'{16'h0002, 16'hEC10, 16'h0000, 16'h0, 16'h0}, chk:16'hEC13, tog:0, exp_done:0, exp_err:1};
    vecs[2] = '{len:16'd4, w:'{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0}, chk:16'hAAAA, tog:1, exp_done:1, exp_err:0};
    vecs[3] = '{len:16'h8001, w:'{16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, chk:16'h0000, tog:0, exp_done:0, exp_err:1};
    vecs[4] = '{len:16'd0, w:'{16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, chk:16'h0000, tog:0, exp_done:1, exp_err:0};
    vecs[5] = '{len:16'd5, w:'{16'hFFFF, 16'h0001, 16'h8000, 16'h8000, 16'h0003}, chk:16'h0003, tog:1, exp_done:1, exp_err:0};

    // Reset state, and no write strobe while held or shortly after release.
    #2;
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_writes", wa_q.size(), 0);
    check("rst_cpu_reset_after", cpu_reset, 1);
    check("rst_in_ready_after", in_ready, 0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset pulled mid-load, then a clean single-word load from address 0.
    clear_mon();
    do_start(16'd5);
    send_word(16'h1234, 0, ok);
    send_word(16'h5678, 0, ok);
    #3 reset = 1'b0;
    #1;
    check("midrst_cpu_reset", cpu_reset, 1);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rom_we", rom_we, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    v = '{len:16'd1, w:'{16'hABCD, 16'h0, 16'h0, 16'h0, 16'h0}, chk:16'hABCD, tog:0, exp_done:1, exp_err:0};
    run_vec(6, v);

    // Full-capacity image: every address written once, no wrap.
    clear_mon();
    do_start(16'h8000);
    for (int i = 0; i < 32768; i++) begin
      send_word(16'(i), 0, ok);
      if (!ok) begin
        check("full_in_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    send_word(16'hC000, 0, ok);
    wait_end("full");
    check("full_write_count", wa_q.size(), 32768);
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++)
      if (wa_q[i] != 15'(i) || wd_q[i] != 16'(i)) bad++;
    check("full_write_contents_bad", bad, 0);
    check("full_last_addr", (wa_q.size() > 0) ? 32'(wa_q[wa_q.size()-1]) : 32'hFFFF_FFFF, 32'h7FFF);
    check("full_done", done, 1);
    check("full_cpu_reset", cpu_reset, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
